// File: rtl/alu_issue_if.sv
// Handshake and payload bundle between register-read, the ALU issue stage and execute.
interface alu_issue_if #(
    parameter int DATA_WIDTH = 64,
    parameter int RD_W       = 5
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [31:0]           inst_i;
    logic [DATA_WIDTH-1:0] pc_i;
    logic [DATA_WIDTH-1:0] rs1_val_i;
    logic [DATA_WIDTH-1:0] rs2_val_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] alu_a_o;
    logic [DATA_WIDTH-1:0] alu_b_o;
    logic [3:0]            alu_op_o;
    logic [RD_W-1:0]       rd_o;
    logic                  illegal_o;
    logic [31:0]           stall_cnt_o;

    modport master (
        output in_valid_i, inst_i, pc_i, rs1_val_i, rs2_val_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_a_o, alu_b_o, alu_op_o, rd_o,
               illegal_o, stall_cnt_o
    );

    modport slave (
        input  in_valid_i, inst_i, pc_i, rs1_val_i, rs2_val_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_a_o, alu_b_o, alu_op_o, rd_o,
               illegal_o, stall_cnt_o
    );
endinterface

// File: rtl/alu_issue.sv
// RV64I issue stage: decodes inst + operands into ALU A/B/opcode behind a skid-buffered handshake.
// Optional backpressure counter enabled by defining ALU_ISSUE_STALL_CNT_EN.
module alu_issue #(
    parameter int DATA_WIDTH = 64,
    parameter int RD_W       = 5
) (
    input logic        clk_i,
    input logic        rst_ni,
    alu_issue_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_COPY = 4'd10;
    localparam logic [3:0] OP_ADDW = 4'd11;
    localparam logic [3:0] OP_SUBW = 4'd12;
    localparam logic [3:0] OP_SLLW = 4'd13;
    localparam logic [3:0] OP_SRLW = 4'd14;
    localparam logic [3:0] OP_SRAW = 4'd15;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [3:0]            op;
        logic [RD_W-1:0]       rd;
        logic                  ill;
    } dec_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    logic [31:0]           inst_s;
    logic [2:0]            funct3_s;
    logic                  alt_s;
    logic [DATA_WIDTH-1:0] imm_i_s;
    logic [DATA_WIDTH-1:0] imm_s_s;
    logic [DATA_WIDTH-1:0] imm_u_s;
    logic [DATA_WIDTH-1:0] shamt6_s;
    logic [DATA_WIDTH-1:0] shamt5_s;
    logic [DATA_WIDTH-1:0] four_s;
    dec_t                  dec_s;

    state_e state_q, state_d;
    dec_t   out_q, out_d;
    dec_t   skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept_s;
    logic   drain_s;

    assign inst_s   = bus.inst_i;
    assign funct3_s = inst_s[14:12];
    assign alt_s    = inst_s[30];
    assign imm_i_s  = {{(DATA_WIDTH-12){inst_s[31]}}, inst_s[31:20]};
    assign imm_s_s  = {{(DATA_WIDTH-12){inst_s[31]}}, inst_s[31:25], inst_s[11:7]};
    assign imm_u_s  = {{(DATA_WIDTH-32){inst_s[31]}}, inst_s[31:12], 12'h000};
    assign shamt6_s = {{(DATA_WIDTH-6){1'b0}}, inst_s[25:20]};
    assign shamt5_s = {{(DATA_WIDTH-5){1'b0}}, inst_s[24:20]};
    assign four_s   = {{(DATA_WIDTH-3){1'b0}}, 3'd4};

    // Instruction decode into ALU operands and opcode
    always_comb begin
        dec_s    = '0;
        dec_s.rd = inst_s[RD_W+6:7];
        case (inst_s[6:0])
            7'b0110011: begin
                dec_s.a = bus.rs1_val_i;
                dec_s.b = bus.rs2_val_i;
                case (funct3_s)
                    3'b000:  dec_s.op = alt_s ? OP_SUB : OP_ADD;
                    3'b001:  dec_s.op = OP_SLL;
                    3'b010:  dec_s.op = OP_SLT;
                    3'b011:  dec_s.op = OP_SLTU;
                    3'b100:  dec_s.op = OP_XOR;
                    3'b101:  dec_s.op = alt_s ? OP_SRA : OP_SRL;
                    3'b110:  dec_s.op = OP_OR;
                    3'b111:  dec_s.op = OP_AND;
                    default: dec_s.op = OP_ADD;
                endcase
            end
            7'b0010011: begin
                dec_s.a = bus.rs1_val_i;
                dec_s.b = imm_i_s;
                case (funct3_s)
                    3'b000:  dec_s.op = OP_ADD;
                    3'b001: begin
                        dec_s.op = OP_SLL;
                        dec_s.b  = shamt6_s;
                    end
                    3'b010:  dec_s.op = OP_SLT;
                    3'b011:  dec_s.op = OP_SLTU;
                    3'b100:  dec_s.op = OP_XOR;
                    3'b101: begin
                        dec_s.op = alt_s ? OP_SRA : OP_SRL;
                        dec_s.b  = shamt6_s;
                    end
                    3'b110:  dec_s.op = OP_OR;
                    3'b111:  dec_s.op = OP_AND;
                    default: dec_s.op = OP_ADD;
                endcase
            end
            7'b0111011: begin
                dec_s.a = bus.rs1_val_i;
                dec_s.b = bus.rs2_val_i;
                case (funct3_s)
                    3'b000:  dec_s.op = alt_s ? OP_SUBW : OP_ADDW;
                    3'b001:  dec_s.op = OP_SLLW;
                    3'b101:  dec_s.op = alt_s ? OP_SRAW : OP_SRLW;
                    default: begin
                        dec_s     = '0;
                        dec_s.ill = 1'b1;
                    end
                endcase
            end
            7'b0011011: begin
                dec_s.a = bus.rs1_val_i;
                case (funct3_s)
                    3'b000: begin
                        dec_s.op = OP_ADDW;
                        dec_s.b  = imm_i_s;
                    end
                    3'b001: begin
                        dec_s.op = OP_SLLW;
                        dec_s.b  = shamt5_s;
                    end
                    3'b101: begin
                        dec_s.op = alt_s ? OP_SRAW : OP_SRLW;
                        dec_s.b  = shamt5_s;
                    end
                    default: begin
                        dec_s     = '0;
                        dec_s.ill = 1'b1;
                    end
                endcase
            end
            7'b0110111: begin
                dec_s.b  = imm_u_s;
                dec_s.op = OP_COPY;
            end
            7'b0010111: begin
                dec_s.a = bus.pc_i;
                dec_s.b = imm_u_s;
            end
            7'b1101111, 7'b1100111: begin
                dec_s.a = bus.pc_i;
                dec_s.b = four_s;
            end
            7'b0000011: begin
                dec_s.a = bus.rs1_val_i;
                dec_s.b = imm_i_s;
            end
            7'b0100011: begin
                dec_s.a = bus.rs1_val_i;
                dec_s.b = imm_s_s;
            end
            default: begin
                dec_s     = '0;
                dec_s.ill = 1'b1;
            end
        endcase
    end

    assign accept_s = bus.in_valid_i && in_ready_q;
    assign drain_s  = out_valid_q && bus.out_ready_i;

    // Output register / skid entry sequencing
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_ONE;
                    out_d   = dec_s;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && drain_s) begin
                    out_d = dec_s;
                end else if (accept_s) begin
                    state_d = ST_FULL;
                    skid_d  = dec_s;
                end else if (drain_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_FULL: begin
                if (drain_s) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // State and data registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.alu_a_o     = out_q.a;
    assign bus.alu_b_o     = out_q.b;
    assign bus.alu_op_o    = out_q.op;
    assign bus.rd_o        = out_q.rd;
    assign bus.illegal_o   = out_q.ill;

`ifdef ALU_ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles the execute stage holds off a valid op
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 32'd0;
        end else if (out_valid_q && !bus.out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
`else
    assign bus.stall_cnt_o = 32'd0;
`endif
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage that drives the RV64I execute ALU. It decodes a 32-bit instruction plus its register operands into ALU operand A, operand B and the 4-bit ALU opcode.
- Output is registered behind a valid/ready handshake with a one-entry skid buffer, so it sits between the register-read stage and the combinational ALU.
- Pipeline latency is one cycle, with full throughput under no backpressure.

Parameters:
- DATA_WIDTH, 64, operand/PC width (from utils_pkg; only 64 supported).
- RD_W, 5, destination register index width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- in_valid_i  in  1  upstream instruction valid.
- in_ready_o  out  1  stage can accept (registered).
- inst_i  in  32  raw instruction.
- pc_i  in  DATA_WIDTH  instruction PC.
- rs1_val_i  in  DATA_WIDTH  rs1 value.
- rs2_val_i  in  DATA_WIDTH  rs2 value.
- out_valid_o  out  1  issued op valid.
- out_ready_i  in  1  execute stage accepts.
- alu_a_o  out  DATA_WIDTH  ALU operand A.
- alu_b_o  out  DATA_WIDTH  ALU operand B.
- alu_op_o  out  4  ALU opcode.
- rd_o  out  RD_W  destination register (inst[11:7]).
- illegal_o  out  1  opcode not handled by this stage.
- stall_cnt_o  out  32  backpressure cycle count (optional feature).

Behaviour:
- ALU opcode encoding (fixed): ADD 0, SUB 1, OR 2, AND 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, COPY_B 10, ADDW 11, SUBW 12, SLLW 13, SRLW 14, SRAW 15.
- Immediates are sign-extended to 64 bits. I = inst[31:20]; S = {inst[31:25], inst[11:7]}; U = {inst[31:12], 12'b0}, sign-extended from bit 31.
- Decode by inst[6:0]:
  - OP 0110011: A=rs1, B=rs2. funct3/inst[30]: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - OP-IMM 0010011: A=rs1, B=I-imm, same funct3 map (no SUB). Shifts use B={58'b0, inst[25:20]}; SRA when inst[30]=1.
  - OP-32 0111011: funct3 000 ADDW/SUBW, 001 SLLW, 101 SRLW/SRAW.
  - OP-IMM-32 0011011: ADDW with I-imm; shifts use B={59'b0, inst[24:20]}.
  - LUI: A=0, B=U, COPY_B.
  - AUIPC: A=pc, B=U, ADD.
  - JAL/JALR: A=pc, B=4, ADD (link value).
  - LOAD: A=rs1, B=I, ADD. STORE: A=rs1, B=S, ADD.
  - Anything else, or an undefined funct3 in OP-32/OP-IMM-32: illegal=1, A=B=0, op ADD, rd=0.
- Handshake:
  - An input transfer occurs when in_valid_i && in_ready_o.
  - An output transfer occurs when out_valid_o && out_ready_i.
  - Output fields are stable while out_valid_o && !out_ready_i.
- Buffering: one output register plus one skid entry; states EMPTY, ONE, FULL.
  - EMPTY + accept → ONE.
  - ONE + accept + no drain → FULL (new op parked in skid).
  - ONE + accept + drain → ONE (output register reloads directly).
  - ONE + drain only → EMPTY.
  - FULL + drain → ONE (skid moves to output register).
  - FULL: in_ready_o=0, so no accept.
- in_ready_o = 1 in EMPTY and ONE, 0 in FULL; it is a registered signal.
- Decode happens on the input side; both registers hold decoded fields.
- Reset (asynchronous, any time, including mid-stall):
  - State → EMPTY; out_valid_o=0; in_ready_o=1.
  - alu_a_o, alu_b_o, alu_op_o, rd_o, illegal_o = 0; stall_cnt_o = 0.
  - In-flight ops are dropped.

Optional Feature:
- ALU_ISSUE_STALL_CNT_EN defined: stall_cnt_o increments by 1 each cycle out_valid_o && !out_ready_i, and saturates at 0xFFFFFFFF.
- Undefined: stall_cnt_o is tied to 0 and no counter is built.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093), rs1=5, out_ready=1 → next cycle out_valid=1, A=5, B=0xFFFFFFFFFFFFFFFF, op=0, rd=1.
- SRAI x1,x2,63 (0x43F15093) → B=63, op=7. SUBW x1,x2,x3 (0x403100BB) → A=rs1, B=rs2, op=12.
- LUI x5,0x80000 (0x800002B7) → A=0, B=0xFFFFFFFF80000000, op=10, rd=5. AUIPC with pc=0x1000 → A=0x1000.
- Backpressure: out_ready=0, issue 3 back-to-back ops.
  - Ops 1 and 2 are accepted; in_ready_o=0 the cycle after op 2.
  - Op 3 is held upstream.
  - Release out_ready → ops drain in order 1, 2, 3 with no loss or duplication.
  - With the macro defined, stall_cnt equals the stalled cycles.
- Illegal: inst 0x0000007F → illegal=1, A=B=0, op=0.
- Assert rst_ni low while FULL → outputs zero immediately (asynchronous); after release, state is EMPTY, in_ready=1, and the next op issues normally.
